// File: rtl/periph_bus_pkg.sv
// Shared definitions for the memory-mapped peripheral bus.
//   - Address window of the peripheral bus and its parked (undecoded) address.
//   - Peripheral register addresses.
//   - Bridge FSM state encoding.
package periph_bus_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] PERIPH_MASK  = 32'hF000_0000;
    localparam logic [31:0] IDLE_ADDR    = 32'h0000_0000;

    localparam logic [31:0] GPIO_BASE    = 32'h4001_4000;
    localparam logic [31:0] PIN_OUT_ADDR = 32'h4001_4800;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_RESP   = ST_RESP
    } bridge_state_t;

    // Word-aligned and inside the peripheral window.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return ((addr & mask) == base) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_lite_bridge.sv
// Core load/store request -> peripheral strobe bus bridge.
// One transaction at a time: IDLE -> SETUP -> ACCESS (xACCESS_CYCLES) -> RESP.
// Out-of-range or misaligned requests go straight to RESP with rsp_err=1.
// Ports:
//   CLK, HRESET            clock, async active-low reset
//   req_valid/ready/write/addr/wdata   core request handshake
//   rsp_valid/ready/rdata/err          core response handshake
//   HWRITE, PADDR, PWDATA, PRDATA      peripheral strobe bus
// All outputs are registered.
module apb_lite_bridge
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = PERIPH_BASE,
    parameter logic [31:0] ADDR_MASK     = PERIPH_MASK,
    parameter logic [31:0] PARK_ADDR     = IDLE_ADDR,
    parameter int          ACCESS_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        HWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA
);

    localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES - 1);
    localparam logic       SINGLE_ACC = (ACCESS_CYCLES == 1);

    bridge_state_t state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          wr, wr_nxt;
    logic          req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, hwrite_nxt;
    logic [31:0]   rsp_rdata_nxt, paddr_nxt, pwdata_nxt;

    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            HWRITE    <= 1'b0;
            PADDR     <= PARK_ADDR;
            PWDATA    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr        <= wr_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            HWRITE    <= hwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
        end
    end

    // Outputs are registered, so each branch computes the value the outputs
    // take in the *next* state.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        wr_nxt        = wr;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;
        hwrite_nxt    = 1'b0;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;

        case (state)
            S_IDLE: begin
                paddr_nxt = PARK_ADDR;
                if (req_ready && req_valid) begin
                    req_ready_nxt = 1'b0;
                    wr_nxt        = req_write;
                    if (addr_ok(req_addr, BASE_ADDR, ADDR_MASK)) begin
                        state_nxt  = S_SETUP;
                        paddr_nxt  = req_addr;
                        pwdata_nxt = req_wdata;
                    end else begin
                        // Rejected without touching the bus.
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end else begin
                    // First IDLE cycle after reset has req_ready low.
                    req_ready_nxt = 1'b1;
                end
            end

            S_SETUP: begin
                state_nxt  = S_ACCESS;
                cnt_nxt    = CNT_LOAD;
                hwrite_nxt = wr && SINGLE_ACC;
            end

            S_ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = wr ? 32'h0 : PRDATA;
                    paddr_nxt     = PARK_ADDR;
                end else begin
                    cnt_nxt    = cnt - 4'd1;
                    // Strobe only in the cycle where the counter will be 0.
                    hwrite_nxt = wr && (cnt == 4'd1);
                end
            end

            S_RESP: begin
                paddr_nxt = PARK_ADDR;
                if (rsp_ready) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                    req_ready_nxt = 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/apb_lite_bridge.md
Name: apb_lite_bridge

Overview:
- Upstream stage of the memory-mapped peripheral bus: converts the core's load/store request (valid/ready handshake) into the peripheral strobe bus (HWRITE, PADDR, PWDATA, PRDATA) consumed by GPIO and pin peripherals such as the pin output block at 0x4001_4800.
- Peripherals decode PADDR combinationally and write on any clock edge where HWRITE=1 and the address matches. The bridge therefore guarantees exactly one HWRITE cycle per store and parks PADDR on an undecoded address when idle.
- It returns read data or an error response to the core over a second valid/ready handshake.

Parameters:
- PERIPH_BASE, 32'h4000_0000, lowest address routed to the peripheral bus.
- PERIPH_MASK, 32'hF000_0000, an address is in range when (req_addr & PERIPH_MASK) == PERIPH_BASE.
- IDLE_ADDR, 32'h0000_0000, value driven on PADDR when no access is in progress; no peripheral may decode it.
- ACCESS_CYCLES, 1, number of ACCESS-state cycles (1..15).

Ports:
- CLK  input  1  system clock, rising edge
- HRESET  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  bridge can accept a request
- req_write  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  core accepts response
- rsp_rdata  output  32  load data (0 for stores and errors)
- rsp_err  output  1  out-of-range or misaligned access
- HWRITE  output  1  peripheral write strobe
- PADDR  output  32  peripheral address
- PWDATA  output  32  peripheral write data
- PRDATA  input  32  peripheral read data (wired/tri-state bus)

Behaviour:
- Single clock CLK. Reset is asynchronous, active-low on HRESET. All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, HWRITE=0, PADDR=IDLE_ADDR, PWDATA=0, state=IDLE, access counter=0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/addr/wdata and set req_ready=0.
  - If the address is in range and req_addr[1:0]==0, go to SETUP. Otherwise go to RESP with rsp_err=1 and rsp_rdata=0; no bus activity occurs.
- SETUP (1 cycle): PADDR=latched addr, PWDATA=latched wdata, HWRITE=0.
  - Counter is loaded with ACCESS_CYCLES-1. Next state is ACCESS.
- ACCESS: PADDR and PWDATA are held.
  - HWRITE=1 only in the final ACCESS cycle (counter==0) and only for stores, so exactly one write edge occurs.
  - The counter decrements each cycle. When it reaches 0:
    - For loads, sample PRDATA into rsp_rdata at that edge.
    - For stores, rsp_rdata=0.
  - Go to RESP with rsp_err=0.
- RESP: PADDR=IDLE_ADDR, HWRITE=0.
  - rsp_valid=1; rsp_rdata and rsp_err are held until rsp_ready=1.
  - On handshake, go to IDLE with req_ready=1 the following cycle.
- Latency, ACCESS_CYCLES=1, no backpressure: accept edge at cycle 0; SETUP cycle 1; ACCESS cycle 2 (write edge / PRDATA sample at the end of cycle 2); rsp_valid high in cycle 3. Error responses assert rsp_valid in cycle 1.
- Throughput: one transaction at a time, with no new accept until the response handshake completes. A back-to-back request held on req_valid is accepted in the first IDLE cycle after RESP.
- req_valid while req_ready=0 is ignored; the core must hold it.
- rsp_ready held high while in IDLE has no effect.
- Reset asserted mid-operation forces reset values immediately, because the reset is asynchronous. A store whose HWRITE edge has not yet occurred is not performed, and no response is issued.
- PWDATA keeps its last value after an access; only PADDR is parked.

Decomposition:
- Shared package periph_bus_pkg: PERIPH_BASE, PERIPH_MASK, IDLE_ADDR, the peripheral address constants (e.g. PIN_OUT_ADDR=32'h4001_4800), and the state encoding (2-bit localparams).
- No sub-module needed; the single FSM with its counter is self-contained.

Test Plan:
- Store 0x0000_0001 to 0x4001_4800 (ACCESS_CYCLES=1) -> HWRITE high for exactly one cycle (cycle 2), PADDR=0x4001_4800 in cycles 1-2, rsp_valid in cycle 3 with err=0 and rdata=0; a pin output model shows PIN_OUT=1.
- Load from 0x4001_4800 after that store -> rsp_rdata=0x0000_0001, rsp_err=0, HWRITE stays 0 throughout.
- Load from 0x2000_0000 and store to 0x4001_4802 -> rsp_valid in cycle 1 with rsp_err=1 and rdata=0; HWRITE never asserts; PADDR stays 0x0000_0000.
- ACCESS_CYCLES=3 store -> HWRITE high only in the third ACCESS cycle; rsp_valid in cycle 5.
- rsp_ready held low 4 cycles in RESP, with a second request on req_valid -> rsp_valid/rdata stable, req_ready=0; the second request is accepted the cycle after the handshake.
- HRESET pulsed low during ACCESS of a store (ACCESS_CYCLES=3, first ACCESS cycle) -> HWRITE=0, PADDR=0, rsp_valid=0 immediately; the peripheral register is unchanged.
